// File: rtl/datapath_sequencer_if.sv
// ============================================================================
// Module      : datapath_sequencer_if
// Description : Command handshake bundle between a requester and the
//               datapath micro-sequencer.
//               Ports (per signal):
//                 cmd_valid  requester -> sequencer  command present
//                 cmd_ready  sequencer -> requester  command can be accepted
//                 cmd_op     2b   00 ALU_RR, 01 ALU_RI, 10 LOAD, 11 STORE
//                 cmd_fs     5b   ALU function select
//                 cmd_c0     1b   ALU carry-in
//                 cmd_da     5b   destination register
//                 cmd_sa     5b   source A / base register
//                 cmd_sb     5b   source B / store-data register
//                 cmd_imm    64b  immediate / address offset
//               Modports: master (requester), slave (sequencer).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface datapath_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_fs;
  logic        cmd_c0;
  logic [4:0]  cmd_da;
  logic [4:0]  cmd_sa;
  logic [4:0]  cmd_sb;
  logic [63:0] cmd_imm;

  modport master (
    output cmd_valid, cmd_op, cmd_fs, cmd_c0, cmd_da, cmd_sa, cmd_sb, cmd_imm,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_fs, cmd_c0, cmd_da, cmd_sa, cmd_sb, cmd_imm,
    output cmd_ready
  );
endinterface

`default_nettype wire

// File: rtl/datapath_sequencer.sv
// ============================================================================
// Module      : datapath_sequencer
// Description : Micro-sequencer in front of the LEGv8 datapath-with-memory.
//               Accepts one register-level command per handshake and expands
//               it into 32-bit control words plus a 64-bit constant, one word
//               per clock. Memory ops run as an address cycle (into TEMP_REG)
//               followed by a memory cycle held for MEM_WAIT extra cycles.
//               Ports:
//                 clock        in   system clock, rising edge
//                 reset        in   asynchronous active-low reset
//                 cmd          slave modport of datapath_sequencer_if
//                 status_in    in   4b datapath status flags
//                 control_word out  32b datapath control word
//                 constant     out  64b datapath constant
//                 status_out   out  4b flags latched from last ALU op
//                 busy         out  command in progress
//                 done         out  pulse in final cycle of a command
//                 op_count     out  16b wrapping done counter   (optional)
//                 mem_cycles   out  16b saturating MEM counter  (optional)
//               Optional feature macro: DATAPATH_SEQ_OPCOUNT_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module datapath_sequencer #(
  parameter logic [4:0] TEMP_REG = 5'd7,
  parameter int         MEM_WAIT = 2,
  parameter logic [4:0] FS_ADD   = 5'b01000
) (
  input  wire logic              clock,
  input  wire logic              reset,
  datapath_sequencer_if.slave    cmd,
  input  wire logic [3:0]        status_in,
  output logic      [31:0]       control_word,
  output logic      [63:0]       constant,
  output logic      [3:0]        status_out,
  output logic                   busy,
  output logic                   done
`ifdef DATAPATH_SEQ_OPCOUNT_EN
  ,
  output logic      [15:0]       op_count,
  output logic      [15:0]       mem_cycles
`endif
);

  localparam logic [1:0] C_OP_ALU_RI = 2'b01;
  localparam logic [1:0] C_OP_STORE  = 2'b11;
  localparam logic [3:0] C_MEM_LAST  = 4'(MEM_WAIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_ADDR = 2'd2,
    S_MEM  = 2'd3
  } state_t;

  state_t      state_q,  state_d;
  logic [1:0]  op_q,     op_d;
  logic [4:0]  fs_q,     fs_d;
  logic        c0_q,     c0_d;
  logic [4:0]  da_q,     da_d;
  logic [4:0]  sa_q,     sa_d;
  logic [4:0]  sb_q,     sb_d;
  logic [63:0] imm_q,    imm_d;
  logic [3:0]  cnt_q,    cnt_d;
  logic [3:0]  status_q, status_d;

  // Control word fields assembled from the current state.
  logic [4:0] w_da, w_sa, w_sb, w_fs, w_aux;
  logic       w_reg_write, w_b_sel, w_c0, w_addr_load, w_alu_bus_en;
  logic       w_mem_write, w_mem_en;
  logic       w_mem_last;

  assign w_mem_last = (cnt_q == C_MEM_LAST);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    fs_d     = fs_q;
    c0_d     = c0_q;
    da_d     = da_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    imm_d    = imm_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    case (state_q)
      S_IDLE: begin
        if (cmd.cmd_valid) begin
          op_d    = cmd.cmd_op;
          fs_d    = cmd.cmd_fs;
          c0_d    = cmd.cmd_c0;
          da_d    = cmd.cmd_da;
          sa_d    = cmd.cmd_sa;
          sb_d    = cmd.cmd_sb;
          imm_d   = cmd.cmd_imm;
          // op[1] separates memory ops from ALU ops
          state_d = cmd.cmd_op[1] ? S_ADDR : S_EXEC;
        end
      end
      S_EXEC: begin
        status_d = status_in;
        state_d  = S_IDLE;
      end
      S_ADDR: begin
        cnt_d   = 4'd0;
        state_d = S_MEM;
      end
      S_MEM: begin
        if (w_mem_last) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      op_q     <= 2'd0;
      fs_q     <= 5'd0;
      c0_q     <= 1'b0;
      da_q     <= 5'd0;
      sa_q     <= 5'd0;
      sb_q     <= 5'd0;
      imm_q    <= 64'd0;
      cnt_q    <= 4'd0;
      status_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      fs_q     <= fs_d;
      c0_q     <= c0_d;
      da_q     <= da_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      imm_q    <= imm_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output decode: outputs depend only on registered state so an async reset
  // drops the word to NOP immediately.
  // --------------------------------------------------------------------------
  always_comb begin
    w_da         = 5'd0;
    w_sa         = 5'd0;
    w_sb         = 5'd0;
    w_fs         = 5'd0;
    w_aux        = 5'd0;
    w_reg_write  = 1'b0;
    w_b_sel      = 1'b0;
    w_c0         = 1'b0;
    w_addr_load  = 1'b0;
    w_alu_bus_en = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_en     = 1'b0;
    constant     = 64'd0;
    done         = 1'b0;
    case (state_q)
      S_EXEC: begin
        w_da         = da_q;
        w_sa         = sa_q;
        w_sb         = sb_q;
        w_fs         = fs_q;
        w_c0         = c0_q;
        w_reg_write  = 1'b1;
        w_alu_bus_en = 1'b1;
        if (op_q == C_OP_ALU_RI) begin
          w_b_sel  = 1'b1;
          constant = imm_q;
        end
        done = 1'b1;
      end
      S_ADDR: begin
        w_da         = TEMP_REG;
        w_sa         = sa_q;
        w_fs         = FS_ADD;
        w_reg_write  = 1'b1;
        w_b_sel      = 1'b1;
        w_alu_bus_en = 1'b1;
        constant     = imm_q;
      end
      S_MEM: begin
        w_sa        = TEMP_REG;
        w_aux       = TEMP_REG;
        w_mem_en    = 1'b1;
        w_addr_load = 1'b1;
        if (op_q == C_OP_STORE) begin
          w_sb        = sb_q;
          w_mem_write = 1'b1;
        end else begin
          // load data is only valid once the wait states have elapsed
          w_da        = da_q;
          w_reg_write = w_mem_last;
        end
        done = w_mem_last;
      end
      default: ;
    endcase
  end

  assign control_word = {w_aux, w_mem_en, w_mem_write, w_alu_bus_en, w_addr_load,
                         w_c0, w_fs, w_b_sel, w_reg_write, w_sb, w_sa, w_da};
  assign status_out    = status_q;
  assign busy          = (state_q != S_IDLE);
  assign cmd.cmd_ready = (state_q == S_IDLE);

`ifdef DATAPATH_SEQ_OPCOUNT_EN
  logic [15:0] op_count_q,   op_count_d;
  logic [15:0] mem_cycles_q, mem_cycles_d;

  always_comb begin
    op_count_d   = op_count_q;
    mem_cycles_d = mem_cycles_q;
    if (done) begin
      op_count_d = op_count_q + 16'd1;
    end
    if ((state_q == S_MEM) && (mem_cycles_q != 16'hFFFF)) begin
      mem_cycles_d = mem_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_count_q   <= 16'd0;
      mem_cycles_q <= 16'd0;
    end else begin
      op_count_q   <= op_count_d;
      mem_cycles_q <= mem_cycles_d;
    end
  end

  assign op_count   = op_count_q;
  assign mem_cycles = mem_cycles_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_datapath_sequencer.sv
// ============================================================================
// Module      : tb_datapath_sequencer
// Description : Self-checking bench for datapath_sequencer. Each command's
//               expected word stream is built from the control-word field
//               rules and compared cycle by cycle.
//               Optional feature macro: DATAPATH_SEQ_OPCOUNT_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_datapath_sequencer;

  localparam int         MW     = 2;
  localparam logic [4:0] TEMP   = 5'd7;
  localparam logic [4:0] FSADD  = 5'b01000;

  typedef struct packed {
    logic [31:0] cw;
    logic [63:0] k;
    logic        dn;
  } word_t;

  logic        clock;
  logic        reset;
  logic [3:0]  status_in;
  logic [31:0] control_word;
  logic [63:0] constant;
  logic [3:0]  status_out;
  logic        busy;
  logic        done;
`ifdef DATAPATH_SEQ_OPCOUNT_EN
  logic [15:0] op_count;
  logic [15:0] mem_cycles;
`endif

  int total = 0;
  int bad   = 0;

  // Reference state
  logic [3:0] exp_status = 4'd0;
  int         n_done     = 0;
  int         n_mem      = 0;

  datapath_sequencer_if cmd_if ();

  datapath_sequencer #(
    .TEMP_REG (TEMP),
    .MEM_WAIT (MW),
    .FS_ADD   (FSADD)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .cmd          (cmd_if),
    .status_in    (status_in),
    .control_word (control_word),
    .constant     (constant),
    .status_out   (status_out),
    .busy         (busy),
    .done         (done)
`ifdef DATAPATH_SEQ_OPCOUNT_EN
    ,
    .op_count     (op_count),
    .mem_cycles   (mem_cycles)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] cw_of(
    input logic [4:0] da, input logic [4:0] sa, input logic [4:0] sb,
    input logic rw, input logic bs, input logic [4:0] fs, input logic c0,
    input logic al, input logic abe, input logic mw, input logic me,
    input logic [4:0] aux);
    return {aux, me, mw, abe, al, c0, fs, bs, rw, sb, sa, da};
  endfunction

  // Drives one command (accepted reps times while cmd_valid is held) and
  // checks every resulting word plus the idle cycle that follows.
  task automatic exercise_cmd(input logic [1:0] op, input logic [4:0] fs,
                              input logic c0, input logic [4:0] da,
                              input logic [4:0] sa, input logic [4:0] sb,
                              input logic [63:0] imm, input logic [3:0] st,
                              input int reps);
    word_t exp_q[$];
    word_t w;
    exp_q = {};
    if (!op[1]) begin
      w.cw = cw_of(da, sa, sb, 1'b1, op[0], fs, c0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
      w.k  = op[0] ? imm : 64'd0;
      w.dn = 1'b1;
      exp_q.push_back(w);
    end else begin
      w.cw = cw_of(TEMP, sa, 5'd0, 1'b1, 1'b1, FSADD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
      w.k  = imm;
      w.dn = 1'b0;
      exp_q.push_back(w);
      for (int i = 0; i <= MW; i++) begin
        if (op[0])
          w.cw = cw_of(5'd0, TEMP, sb, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, TEMP);
        else
          w.cw = cw_of(da, TEMP, 5'd0, (i == MW), 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, TEMP);
        w.k  = 64'd0;
        w.dn = (i == MW);
        exp_q.push_back(w);
      end
    end

    @(posedge clock); #1;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_fs    = fs;
    cmd_if.cmd_c0    = c0;
    cmd_if.cmd_da    = da;
    cmd_if.cmd_sa    = sa;
    cmd_if.cmd_sb    = sb;
    cmd_if.cmd_imm   = imm;
    status_in        = st;

    for (int r = 0; r < reps; r++) begin
      @(negedge clock);
      total++;
      if (cmd_if.cmd_ready !== 1'b1) begin
        bad++;
        $display("FAIL ready_idle op=%0d rep=%0d: got %b want 1", op, r, cmd_if.cmd_ready);
      end
      total++;
      if (control_word !== 32'h0) begin
        bad++;
        $display("FAIL nop_idle op=%0d rep=%0d: got %h want 00000000", op, r, control_word);
      end
      @(posedge clock); #1;
      if (r == reps - 1) begin
        // scramble the bus so the words must come from latched fields
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 2'($urandom);
        cmd_if.cmd_fs    = 5'($urandom);
        cmd_if.cmd_c0    = 1'($urandom);
        cmd_if.cmd_da    = 5'($urandom);
        cmd_if.cmd_sa    = 5'($urandom);
        cmd_if.cmd_sb    = 5'($urandom);
        cmd_if.cmd_imm   = {$urandom, $urandom};
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        @(negedge clock);
        total++;
        if (control_word !== exp_q[i].cw) begin
          bad++;
          $display("FAIL cw op=%0d word=%0d: got %h want %h", op, i, control_word, exp_q[i].cw);
        end
        total++;
        if (constant !== exp_q[i].k) begin
          bad++;
          $display("FAIL constant op=%0d word=%0d: got %h want %h", op, i, constant, exp_q[i].k);
        end
        total++;
        if (done !== exp_q[i].dn) begin
          bad++;
          $display("FAIL done op=%0d word=%0d: got %b want %b", op, i, done, exp_q[i].dn);
        end
        total++;
        if (busy !== 1'b1 || cmd_if.cmd_ready !== 1'b0) begin
          bad++;
          $display("FAIL busy_ready op=%0d word=%0d: got busy=%b ready=%b want busy=1 ready=0",
                   op, i, busy, cmd_if.cmd_ready);
        end
        @(posedge clock); #1;
      end
      if (!op[1]) exp_status = st;
      else        n_mem += MW + 1;
      n_done++;
    end

    @(negedge clock);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || control_word !== 32'h0) begin
      bad++;
      $display("FAIL end_idle op=%0d: got busy=%b done=%b cw=%h want 0 0 00000000",
               op, busy, done, control_word);
    end
    total++;
    if (status_out !== exp_status) begin
      bad++;
      $display("FAIL status_out op=%0d: got %h want %h", op, status_out, exp_status);
    end
  endtask

  task automatic test_reset();
    reset            = 1'b0;
    status_in        = 4'd0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'd0;
    cmd_if.cmd_fs    = 5'd0;
    cmd_if.cmd_c0    = 1'b0;
    cmd_if.cmd_da    = 5'd0;
    cmd_if.cmd_sa    = 5'd0;
    cmd_if.cmd_sb    = 5'd0;
    cmd_if.cmd_imm   = 64'd0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    total++;
    if (control_word !== 32'h0) begin
      bad++; $display("FAIL rst_cw: got %h want 00000000", control_word);
    end
    total++;
    if (constant !== 64'h0) begin
      bad++; $display("FAIL rst_constant: got %h want 0", constant);
    end
    total++;
    if (status_out !== 4'h0) begin
      bad++; $display("FAIL rst_status: got %h want 0", status_out);
    end
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL rst_busy_done: got %b%b want 00", busy, done);
    end
    total++;
    if (cmd_if.cmd_ready !== 1'b1) begin
      bad++; $display("FAIL rst_ready: got %b want 1", cmd_if.cmd_ready);
    end
  endtask

  task automatic test_directed();
    exercise_cmd(2'b01, 5'b00100, 1'b0, 5'd0, 5'd31, 5'd0, 64'd24, 4'b0110, 1);
    exercise_cmd(2'b00, 5'b01001, 1'b1, 5'd1, 5'd31, 5'd0, 64'd0, 4'b1010, 1);
    exercise_cmd(2'b11, 5'b00000, 1'b0, 5'd0, 5'd31, 5'd1, 64'd24, 4'b0101, 1);
    exercise_cmd(2'b10, 5'b00000, 1'b0, 5'd2, 5'd31, 5'd0, 64'd24, 4'b1111, 1);
    // R31 destination passes through untouched
    exercise_cmd(2'b01, 5'b11111, 1'b1, 5'd31, 5'd31, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0011, 1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      exercise_cmd(2'($urandom), 5'($urandom), 1'($urandom), 5'($urandom),
                   5'($urandom), 5'($urandom), {$urandom, $urandom}, 4'($urandom), 1);
    end
  endtask

  task automatic test_back_to_back();
    exercise_cmd(2'b11, 5'($urandom), 1'b0, 5'd3, 5'd4, 5'd5, 64'h1234, 4'b1001, 2);
    exercise_cmd(2'b00, 5'b00011, 1'b0, 5'd6, 5'd8, 5'd9, 64'd0, 4'b1100, 3);
  endtask

  task automatic test_reset_mid_store();
    @(posedge clock); #1;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = 2'b11;
    cmd_if.cmd_sa    = 5'd31;
    cmd_if.cmd_sb    = 5'd1;
    cmd_if.cmd_imm   = 64'd24;
    @(posedge clock); #1;        // accepted: ADDR cycle
    cmd_if.cmd_valid = 1'b0;
    @(posedge clock);            // MEM cycle 1
    @(posedge clock); #2;        // MEM cycle 2
    total++;
    if (busy !== 1'b1 || control_word[26] !== 1'b1) begin
      bad++; $display("FAIL pre_rst_mem: got busy=%b mem_en=%b want 1 1", busy, control_word[26]);
    end
    reset = 1'b0;
    #1;
    total++;
    if (control_word !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || constant !== 64'h0) begin
      bad++;
      $display("FAIL async_rst: got cw=%h busy=%b done=%b k=%h want 0 0 0 0",
               control_word, busy, done, constant);
    end
    exp_status = 4'd0;
    n_done     = 0;
    n_mem      = 0;
    @(posedge clock); #1;
    reset = 1'b1;
    exercise_cmd(2'b10, 5'd0, 1'b0, 5'd10, 5'd11, 5'd0, 64'hABCD, 4'b0111, 1);
  endtask

  task automatic test_counters();
`ifdef DATAPATH_SEQ_OPCOUNT_EN
    @(negedge clock);
    total++;
    if (op_count !== 16'(n_done)) begin
      bad++; $display("FAIL op_count: got %0d want %0d", op_count, n_done);
    end
    total++;
    if (mem_cycles !== 16'(n_mem)) begin
      bad++; $display("FAIL mem_cycles: got %0d want %0d", mem_cycles, n_mem);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_store();
    test_counters();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
